// File: rtl/delay_timer_seq_if.sv
// delay_timer_seq_if
//   Table-programming bus for delay_timer_seq. The host side (master) writes
//   one table entry per cfg_we strobe; the sequencer (slave) accepts it only
//   while idle.
//   Signals:
//     cfg_we    table write strobe
//     cfg_addr  table entry index (AW bits)
//     cfg_wb    entry weight
//     cfg_mode  entry mode {A,B}
//     cfg_hold  entry trigger-high cycle count (0 behaves as 1)
interface delay_timer_seq_if #(
  parameter int AW = 3
);
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_wb;
  logic [1:0]    cfg_mode;
  logic [7:0]    cfg_hold;

  modport master (output cfg_we, cfg_addr, cfg_wb, cfg_mode, cfg_hold);
  modport slave  (input  cfg_we, cfg_addr, cfg_wb, cfg_mode, cfg_hold);
endinterface

// File: rtl/delay_timer_seq.sv
// delay_timer_seq
//   Steps a delay_timer through a table of {weight, mode, hold} entries. For
//   each entry it holds the timer in reset while loading the pins, releases
//   it, fires a trigger pulse of the programmed width, then waits until the
//   timer output has been inactive for weight+SETTLE cycles, reporting how
//   many cycles the output was active.
//   Ports:
//     clk, RESET_n      clock, asynchronous active-low reset
//     bus               table write bus (slave side)
//     cfg_last          index of the final step, latched on start
//     start, abort      sequence control
//     i_delay_out       timer output, active low
//     o_wb, o_A, o_B    weight and mode pins to the timer
//     o_TRIG            trigger to the timer
//     o_tmr_reset       active-high reset to the timer
//     busy, o_step      sequencer status and current entry
//     meas_valid/o_meas per-step active-cycle measurement
//     done              normal completion pulse
//     timeout_err       sticky step timeout flag
module delay_timer_seq #(
  parameter int DEPTH   = 8,
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 1023,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            RESET_n,
  delay_timer_seq_if.slave bus,
  input  logic [AW-1:0]   cfg_last,
  input  logic            start,
  input  logic            abort,
  input  logic            i_delay_out,
  output logic [7:0]      o_wb,
  output logic            o_A,
  output logic            o_B,
  output logic            o_TRIG,
  output logic            o_tmr_reset,
  output logic            busy,
  output logic [AW-1:0]   o_step,
  output logic            meas_valid,
  output logic [8:0]      o_meas,
  output logic            done,
  output logic            timeout_err
);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, TRIG_HI, WAIT, NEXT} state_t;

  localparam logic [11:0] TIMEOUT_M1 = 12'(TIMEOUT - 1);

  function automatic logic [8:0] sat_inc9(input logic [8:0] v, input logic en);
    return (en && v != 9'h1FF) ? v + 9'd1 : v;
  endfunction

  state_t        state;
  logic [17:0]   mem [DEPTH];
  logic          out_q;
  logic [7:0]    cnt;
  logic [7:0]    hold_q;
  logic [8:0]    quiet;
  logic [11:0]   waitc;
  logic [8:0]    meas;
  logic [AW-1:0] last_q;

  logic          wr_en;
  logic [17:0]   wr_entry;
  logic [17:0]   first_entry;
  logic [AW-1:0] step_inc;
  logic          active;
  logic [8:0]    meas_nxt;
  logic [7:0]    hold_eff;
  logic [9:0]    quiet_target;

  assign wr_en    = bus.cfg_we && (state == IDLE);
  assign wr_entry = {bus.cfg_wb, bus.cfg_mode, bus.cfg_hold};
  // A write to entry 0 in the same cycle as start must be seen by the very
  // first LOAD cycle, so forward it past the table.
  assign first_entry  = (wr_en && bus.cfg_addr == '0) ? wr_entry : mem[0];
  assign step_inc     = o_step + 1'b1;
  assign active       = ~out_q;
  assign meas_nxt     = sat_inc9(meas, active);
  assign hold_eff     = (hold_q == 8'd0) ? 8'd1 : hold_q;
  assign quiet_target = {2'b00, o_wb} + 10'(SETTLE);

  // Table storage: not reset, written only while idle
  always_ff @(posedge clk) begin
    if (wr_en) mem[bus.cfg_addr] <= wr_entry;
  end

  // Sequencer: state, counters and registered pin outputs
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= IDLE;
      out_q       <= 1'b1;
      cnt         <= '0;
      hold_q      <= '0;
      quiet       <= '0;
      waitc       <= '0;
      meas        <= '0;
      last_q      <= '0;
      o_wb        <= '0;
      o_A         <= 1'b0;
      o_B         <= 1'b0;
      o_TRIG      <= 1'b0;
      o_tmr_reset <= 1'b1;
      busy        <= 1'b0;
      o_step      <= '0;
      meas_valid  <= 1'b0;
      o_meas      <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      out_q      <= i_delay_out;
      meas_valid <= 1'b0;
      done       <= 1'b0;
      if (state != IDLE && abort) begin
        state       <= IDLE;
        o_TRIG      <= 1'b0;
        o_tmr_reset <= 1'b1;
        busy        <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              state       <= LOAD;
              busy        <= 1'b1;
              o_step      <= '0;
              last_q      <= cfg_last;
              timeout_err <= 1'b0;
              cnt         <= '0;
              {o_wb, o_A, o_B, hold_q} <= first_entry;
            end
          end
          LOAD: begin
            {o_wb, o_A, o_B, hold_q} <= mem[o_step];
            meas <= '0;
            if (cnt[0]) begin
              state       <= ARM;
              cnt         <= '0;
              o_tmr_reset <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ARM: begin
            if (cnt[0]) begin
              state  <= TRIG_HI;
              cnt    <= '0;
              o_TRIG <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          TRIG_HI: begin
            meas <= meas_nxt;
            if (cnt == hold_eff - 8'd1) begin
              state  <= WAIT;
              o_TRIG <= 1'b0;
              quiet  <= '0;
              waitc  <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          WAIT: begin
            meas  <= meas_nxt;
            quiet <= active ? 9'd0 : quiet + 9'd1;
            waitc <= waitc + 12'd1;
            if ({1'b0, quiet} == quiet_target) begin
              state      <= NEXT;
              meas_valid <= 1'b1;
              o_meas     <= meas_nxt;
            end else if (waitc == TIMEOUT_M1) begin
              state       <= IDLE;
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              o_tmr_reset <= 1'b1;
            end
          end
          NEXT: begin
            o_tmr_reset <= 1'b1;
            cnt         <= '0;
            if (o_step == last_q) begin
              state <= IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state  <= LOAD;
              o_step <= step_inc;
              {o_wb, o_A, o_B, hold_q} <= mem[step_inc];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_timer_seq.sv
module tb_delay_timer_seq;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 50;
  localparam logic [27:0] RST_VEC = 28'h800_0000;

  logic          clk = 1'b0;
  logic          RESET_n = 1'b0;
  logic [AW-1:0] cfg_last = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          i_delay_out;
  logic [7:0]    o_wb;
  logic          o_A, o_B, o_TRIG, o_tmr_reset, busy;
  logic [AW-1:0] o_step;
  logic          meas_valid;
  logic [8:0]    o_meas;
  logic          done, timeout_err;

  int nvec = 0;
  int nerr = 0;

  delay_timer_seq_if #(.AW(AW)) bus();

  delay_timer_seq #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .RESET_n(RESET_n), .bus(bus), .cfg_last(cfg_last),
    .start(start), .abort(abort), .i_delay_out(i_delay_out),
    .o_wb(o_wb), .o_A(o_A), .o_B(o_B), .o_TRIG(o_TRIG),
    .o_tmr_reset(o_tmr_reset), .busy(busy), .o_step(o_step),
    .meas_valid(meas_valid), .o_meas(o_meas), .done(done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Stand-in timer: on a trigger rising edge the output goes active (low)
  // for wb cycles, then returns inactive; held inactive while in reset.
  logic [8:0] rem;
  logic       trig_d;
  logic       force_low = 1'b0;
  always @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      rem    <= '0;
      trig_d <= 1'b0;
    end else begin
      trig_d <= o_TRIG;
      if (o_tmr_reset)           rem <= '0;
      else if (o_TRIG && !trig_d) rem <= {1'b0, o_wb};
      else if (rem != 0)          rem <= rem - 9'd1;
    end
  end
  assign i_delay_out = force_low ? 1'b0 : (rem == 9'd0);

  logic [27:0] out_vec;
  assign out_vec = {o_tmr_reset, o_wb, o_A, o_B, o_TRIG, busy, o_step,
                    meas_valid, o_meas, done, timeout_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [7:0] wb,
                             input logic [1:0] md, input logic [7:0] hd);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wb = wb;
    bus.cfg_mode = md; bus.cfg_hold = hd;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    nvec++;
    if (out_vec !== RST_VEC) begin
      nerr++; $display("FAIL reset_values got %h want %h", out_vec, RST_VEC);
    end
    RESET_n = 1'b1;
    tick();
    nvec++;
    if (out_vec !== RST_VEC) begin
      nerr++; $display("FAIL idle_after_reset got %h want %h", out_vec, RST_VEC);
    end
  endtask

  task automatic test_single();
    int n;
    int h;
    write_entry(0, 8'd10, 2'b00, 8'd2);
    cfg_last = 0;
    pulse_start();
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy got %b want 1", busy); end
    n = 0;
    while (!o_TRIG && n < 20) begin tick(); n++; end
    nvec++;
    if (n != 4) begin nerr++; $display("FAIL single_trig_latency got %0d want 4", n); end
    h = 0;
    while (o_TRIG && h < 300) begin h++; tick(); end
    nvec++;
    if (h != 2) begin nerr++; $display("FAIL single_trig_width got %0d want 2", h); end
    n = 0;
    while (!meas_valid && n < 200) begin tick(); n++; end
    nvec++;
    if (meas_valid !== 1'b1) begin nerr++; $display("FAIL single_meas_seen got %b want 1", meas_valid); end
    // Trigger high after edge T -> timer low T+1..T+10 -> out_q low 10 cycles
    nvec++;
    if (o_meas !== 9'd10) begin nerr++; $display("FAIL single_meas got %0d want 10", o_meas); end
    tick();
    nvec++;
    if ({done, busy, o_tmr_reset, meas_valid} !== 4'b1010) begin
      nerr++; $display("FAIL single_done got %b want 1010", {done, busy, o_tmr_reset, meas_valid});
    end
    tick();
    nvec++;
    if (done !== 1'b0) begin nerr++; $display("FAIL single_done_pulse got %b want 0", done); end
  endtask

  task automatic test_multi();
    logic [1:0] md [3];
    int k;
    int dn;
    bit fin;
    md[0] = 2'b00; md[1] = 2'b10; md[2] = 2'b11;
    for (int i = 0; i < 3; i++) write_entry(AW'(i), 8'(5 + i), md[i], 8'd1);
    cfg_last = 2;
    pulse_start();
    k = 0; dn = 0; fin = 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      tick();
      if (meas_valid) begin
        nvec++;
        if ({o_step, o_meas, o_wb, o_A, o_B} !== {AW'(k), 9'(5 + k), 8'(5 + k), md[k % 3]}) begin
          nerr++;
          $display("FAIL multi_step%0d got step=%0d meas=%0d wb=%0d ab=%b want step=%0d meas=%0d wb=%0d ab=%b",
                   k, o_step, o_meas, o_wb, {o_A, o_B}, k, 5 + k, 5 + k, md[k % 3]);
        end
        k++;
      end
      if (done) begin dn++; fin = 1; end
    end
    for (int c = 0; c < 5; c++) begin tick(); if (done) dn++; end
    nvec++;
    if (k != 3) begin nerr++; $display("FAIL multi_meas_count got %0d want 3", k); end
    nvec++;
    if (dn != 1) begin nerr++; $display("FAIL multi_done_count got %0d want 1", dn); end
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL multi_busy_after got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int n;
    int bad;
    write_entry(0, 8'd10, 2'b00, 8'd1);
    cfg_last = 0;
    force_low = 1'b1;
    pulse_start();
    n = 0;
    while (!o_TRIG && n < 20) begin tick(); n++; end
    while (o_TRIG && n < 40) begin tick(); n++; end
    n = 0; bad = 0;
    while (!timeout_err && n < 200) begin
      tick(); n++;
      if (meas_valid || done) bad++;
    end
    nvec++;
    if (n != TIMEOUT) begin nerr++; $display("FAIL timeout_cycles got %0d want %0d", n, TIMEOUT); end
    nvec++;
    if ({timeout_err, busy, o_tmr_reset, o_TRIG} !== 4'b1010) begin
      nerr++; $display("FAIL timeout_state got %b want 1010", {timeout_err, busy, o_tmr_reset, o_TRIG});
    end
    nvec++;
    if (bad != 0) begin nerr++; $display("FAIL timeout_no_pulses got %0d want 0", bad); end
    force_low = 1'b0;
    tick(); tick();
    nvec++;
    if (timeout_err !== 1'b1) begin nerr++; $display("FAIL timeout_sticky got %b want 1", timeout_err); end
    pulse_start();
    nvec++;
    if ({timeout_err, busy} !== 2'b01) begin
      nerr++; $display("FAIL timeout_clear got %b want 01", {timeout_err, busy});
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    int bad;
    write_entry(0, 8'd10, 2'b00, 8'd6);
    cfg_last = 0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL abort_wins_start got %b want 0", busy); end
    pulse_start();
    n = 0;
    while (!o_TRIG && n < 20) begin tick(); n++; end
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    nvec++;
    if ({o_TRIG, o_tmr_reset, busy, done, meas_valid} !== 5'b01000) begin
      nerr++; $display("FAIL abort_trig got %b want 01000", {o_TRIG, o_tmr_reset, busy, done, meas_valid});
    end
    bad = 0;
    for (int c = 0; c < 40; c++) begin tick(); if (done || meas_valid || busy) bad++; end
    nvec++;
    if (bad != 0) begin nerr++; $display("FAIL abort_quiet got %0d want 0", bad); end
  endtask

  task automatic test_cfg_start();
    int n;
    write_entry(0, 8'd20, 2'b00, 8'd3);
    cfg_last = 0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 0; bus.cfg_wb = 8'd12;
    bus.cfg_mode = 2'b01; bus.cfg_hold = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0; bus.cfg_we = 1'b0;
    nvec++;
    if ({o_wb, o_A, o_B} !== {8'd12, 2'b01}) begin
      nerr++; $display("FAIL cfg_bypass got wb=%0d ab=%b want wb=12 ab=01", o_wb, {o_A, o_B});
    end
    tick();
    write_entry(0, 8'd99, 2'b10, 8'd4);
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    nvec++;
    if (done !== 1'b1) begin nerr++; $display("FAIL cfg_run_done got %b want 1", done); end
    tick();
    pulse_start();
    nvec++;
    if ({o_wb, o_A, o_B} !== {8'd12, 2'b01}) begin
      nerr++; $display("FAIL cfg_busy_write got wb=%0d ab=%b want wb=12 ab=01", o_wb, {o_A, o_B});
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_hold0();
    int n;
    int h;
    write_entry(0, 8'd4, 2'b00, 8'd0);
    cfg_last = 0;
    pulse_start();
    n = 0;
    while (!o_TRIG && n < 20) begin tick(); n++; end
    h = 0;
    while (o_TRIG && h < 20) begin h++; tick(); end
    nvec++;
    if (h != 1) begin nerr++; $display("FAIL hold0_width got %0d want 1", h); end
    tick(); tick();
    nvec++;
    if ({busy, o_tmr_reset} !== 2'b10) begin
      nerr++; $display("FAIL hold0_in_wait got %b want 10", {busy, o_tmr_reset});
    end
    #2;
    RESET_n = 1'b0;
    #1;
    nvec++;
    if (out_vec !== RST_VEC) begin
      nerr++; $display("FAIL async_reset got %h want %h", out_vec, RST_VEC);
    end
    tick();
    RESET_n = 1'b1;
    tick(); tick();
    nvec++;
    if (out_vec !== RST_VEC) begin
      nerr++; $display("FAIL reset_release got %h want %h", out_vec, RST_VEC);
    end
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wb = '0;
    bus.cfg_mode = '0; bus.cfg_hold = '0;
    test_reset();
    test_single();
    test_multi();
    test_timeout();
    test_abort();
    test_cfg_start();
    test_hold0();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/delay_timer_seq.md
# delay_timer_seq

Sequencer that programs and exercises one `delay_timer` instance from a small table of steps. Each step supplies a weight and A/B mode, holds the timer in reset, fires a trigger pulse of programmed width, then waits for the timer output to settle, measuring the active-output duration. It sits between a host/config interface and the `delay_timer` pins, driving `i_wb`, `i_A`, `i_B`, `i_TRIG` and `RESET`, and observing `o_delay_out`.

## Interface
- DEPTH, 8: number of table entries (power of 2, ≥2); AW = $clog2(DEPTH)
- SETTLE, 8: quiet-cycle margin added to weight for step completion
- TIMEOUT, 1023: max WAIT cycles per step before error (≤ 4095)

Ports:
- clk  in  1  system clock; all logic rising-edge
- RESET_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  table write strobe (ignored while busy)
- cfg_addr  in  AW  table entry index
- cfg_wb  in  8  entry weight → o_wb
- cfg_mode  in  2  entry mode {A,B}: 00 OS, 01 DO, 10 DR, 11 DD
- cfg_hold  in  8  entry trigger-high cycles (0 treated as 1)
- cfg_last  in  AW  index of final step; sampled on accepted start
- start  in  1  begin sequence at entry 0 (IDLE only)
- abort  in  1  terminate sequence
- i_delay_out  in  1  timer output, active low
- o_wb  out  8  weight to timer
- o_A, o_B  out  1 each  mode pins to timer
- o_TRIG  out  1  trigger to timer
- o_tmr_reset  out  1  active-high RESET to timer
- busy  out  1  high in any state but IDLE
- o_step  out  AW  current entry index
- meas_valid  out  1  one-cycle pulse at step end
- o_meas  out  9  active-output cycle count of completed step
- done  out  1  one-cycle pulse on normal sequence completion
- timeout_err  out  1  sticky step-timeout flag

## Operation
- Table: DEPTH × 18 bits {wb, mode, hold}, synchronous write, contents undefined after reset.
- i_delay_out registered once (out_q); all monitoring uses out_q, active = (out_q==0).
- States: IDLE, LOAD, ARM, TRIG_HI, WAIT, NEXT.
- IDLE: o_tmr_reset=1, o_TRIG=0. start (and no abort) → LOAD, o_step=0, latch cfg_last, clear timeout_err.
- LOAD (2 cycles): o_tmr_reset=1, o_wb/o_A/o_B driven from entry o_step; meas counter cleared → ARM.
- ARM (2 cycles): o_tmr_reset=0, o_TRIG=0 → TRIG_HI.
- TRIG_HI (max(hold,1) cycles): o_TRIG=1 → WAIT.
- WAIT: o_TRIG=0. quiet counter (9-bit) increments when out_q inactive, clears when active. Completes when quiet == wb+SETTLE → NEXT. wait counter (12-bit) increments each cycle; reaching TIMEOUT → timeout_err=1, IDLE, no meas_valid, no done.
- Meas counter: 9-bit, saturates at 511, increments every TRIG_HI/WAIT cycle with out_q active.
- NEXT (1 cycle): meas_valid=1, o_meas=meas count. If o_step==latched last → done=1, IDLE; else o_step+1 → LOAD.
- o_wb/o_A/o_B hold last loaded values in IDLE.
- abort in any non-IDLE state: IDLE next cycle, o_TRIG=0, o_tmr_reset=1, no done/meas_valid; timeout_err unchanged.

## Timing
- Reset values: o_tmr_reset=1; o_wb=0, o_A=o_B=0, o_TRIG=0, busy=0, o_step=0, meas_valid=0, o_meas=0, done=0, timeout_err=0; state IDLE.
- start sampled at edge N → busy=1 and LOAD from edge N+1; o_TRIG first high at edge N+5.
- Per step: 2 LOAD + 2 ARM + max(hold,1) TRIG_HI + WAIT + 1 NEXT cycles.
- cfg_we and start same IDLE cycle: write lands; step 0 loads updated entry.
- abort and start same IDLE cycle: abort wins, start ignored.
- start while busy, cfg_we while busy: ignored.
- Meas saturation: 511 held, no wrap. o_step wraps never (bounded by cfg_last).
- RESET_n low mid-sequence: immediate return to reset values, including o_tmr_reset=1.

## Test plan
- Entry0 {wb=10, mode=00, hold=2}, cfg_last=0, start with timer model → o_TRIG high 2 cycles, meas_valid with o_meas≈10 (±2), done one cycle later in IDLE.
- Three entries (OS, DR, DD, wb=5/6/7), cfg_last=2 → three meas_valid pulses, o_step 0→1→2, single done, busy low afterward.
- i_delay_out forced low constantly, TIMEOUT=50 → timeout_err=1 exactly 50 WAIT cycles in, no done, o_tmr_reset=1; next start clears timeout_err.
- abort during TRIG_HI → next cycle o_TRIG=0, o_tmr_reset=1, busy=0, no done/meas_valid.
- cfg_we to entry 0 with start same cycle → o_wb equals new value in first LOAD cycle; cfg_we while busy leaves table unchanged (verify on rerun).
- hold=0 → o_TRIG high exactly 1 cycle; RESET_n pulsed low in WAIT → all outputs at reset values immediately.
